// File: rtl/i2s_codec_master.sv
// I2S master in the codec role: derives bclk/lrck from clk, serializes a held sample pair on adcdat, deserializes dacdat.
// All outputs registered; one-entry tx holding register (tx_ready low while full); rx_valid pulses without backpressure.
module i2s_codec_master #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              rx_valid,
    output logic              bclk,
    output logic              adclrck,
    output logic              daclrck,
    output logic              adcdat,
    input  logic              dacdat
);

    if (SLOT_W < DATA_W + 1) begin : g_bad_slot
        $error("SLOT_W must be at least DATA_W+1");
    end
    if (BCLK_DIV < 2) begin : g_bad_div
        $error("BCLK_DIV must be at least 2");
    end

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0]  SLOT_FIRST = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0]  POS_LAST   = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0]  RX_LAST    = BIT_W'(SLOT_W + DATA_W);
    localparam logic [DATA_W-1:0] MSB_ONE    = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              bclk_q, bclk_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              lrck_q, lrck_d;
    logic              adcdat_q, adcdat_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] tx_l_sr_q, tx_l_sr_d;
    logic [DATA_W-1:0] tx_r_sr_q, tx_r_sr_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic [DATA_W-1:0] rx_l_sr_q, rx_l_sr_d;
    logic [DATA_W-1:0] rx_r_sr_q, rx_r_sr_d;
    logic [DATA_W-1:0] rx_left_q, rx_left_d;
    logic [DATA_W-1:0] rx_right_q, rx_right_d;
    logic              rx_pend_q, rx_pend_d;
    logic              rx_valid_q, rx_valid_d;

    logic              terminal;
    logic              rise_tick;
    logic              fall_tick;
    logic              frame_load;
    logic              accept;
    logic              cur_slot;
    logic              new_slot;
    logic [BIT_W-1:0]  cur_pos;
    logic [BIT_W-1:0]  new_pos;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] tx_mask;

    always_comb begin
        terminal  = (div_cnt_q == DIV_LAST);
        rise_tick = terminal && !bclk_q;
        fall_tick = terminal && bclk_q;
        accept    = tx_valid && tx_ready_q;

        div_cnt_d = terminal ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = terminal ? !bclk_q : bclk_q;

        bit_cnt_d = bit_cnt_q;
        if (fall_tick) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        end
        frame_load = fall_tick && (bit_cnt_q == BIT_LAST);

        cur_slot = (bit_cnt_q >= SLOT_FIRST);
        cur_pos  = cur_slot ? bit_cnt_q - SLOT_FIRST : bit_cnt_q;
        new_slot = (bit_cnt_d >= SLOT_FIRST);
        new_pos  = new_slot ? bit_cnt_d - SLOT_FIRST : bit_cnt_d;

        // A load on the same edge as an accept consumes the old pair first.
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        tx_l_sr_d     = tx_l_sr_q;
        tx_r_sr_d     = tx_r_sr_q;
        tx_underrun_d = 1'b0;
        if (frame_load) begin
            if (hold_full_q) begin
                tx_l_sr_d = hold_l_q;
                tx_r_sr_d = hold_r_q;
            end else begin
                tx_l_sr_d     = '0;
                tx_r_sr_d     = '0;
                tx_underrun_d = 1'b1;
            end
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = tx_left;
            hold_r_d    = tx_right;
        end
        tx_ready_d = !hold_full_d;

        // Slot position p carries word bit DATA_W-p, so MSB lands one bclk after the lrck edge.
        tx_word  = new_slot ? tx_r_sr_q : tx_l_sr_q;
        tx_mask  = MSB_ONE >> (new_pos - BIT_W'(1));
        lrck_d   = lrck_q;
        adcdat_d = adcdat_q;
        if (fall_tick) begin
            lrck_d   = new_slot;
            adcdat_d = (new_pos != '0 && new_pos <= POS_LAST) ? |(tx_word & tx_mask) : 1'b0;
        end

        rx_l_sr_d = rx_l_sr_q;
        rx_r_sr_d = rx_r_sr_q;
        if (rise_tick && cur_pos != '0 && cur_pos <= POS_LAST) begin
            if (cur_slot) begin
                rx_r_sr_d = {rx_r_sr_q[DATA_W-2:0], dacdat};
            end else begin
                rx_l_sr_d = {rx_l_sr_q[DATA_W-2:0], dacdat};
            end
        end
        rx_pend_d  = rise_tick && (bit_cnt_q == RX_LAST);
        rx_valid_d = rx_pend_q;
        rx_left_d  = rx_pend_q ? rx_l_sr_q : rx_left_q;
        rx_right_d = rx_pend_q ? rx_r_sr_q : rx_right_q;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= BIT_LAST;
            lrck_q        <= 1'b0;
            adcdat_q      <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            tx_l_sr_q     <= '0;
            tx_r_sr_q     <= '0;
            tx_ready_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_l_sr_q     <= '0;
            rx_r_sr_q     <= '0;
            rx_left_q     <= '0;
            rx_right_q    <= '0;
            rx_pend_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            lrck_q        <= lrck_d;
            adcdat_q      <= adcdat_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            tx_l_sr_q     <= tx_l_sr_d;
            tx_r_sr_q     <= tx_r_sr_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            rx_l_sr_q     <= rx_l_sr_d;
            rx_r_sr_q     <= rx_r_sr_d;
            rx_left_q     <= rx_left_d;
            rx_right_q    <= rx_right_d;
            rx_pend_q     <= rx_pend_d;
            rx_valid_q    <= rx_valid_d;
        end
    end

    assign bclk        = bclk_q;
    assign adclrck     = lrck_q;
    assign daclrck     = lrck_q;
    assign adcdat      = adcdat_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_left     = rx_left_q;
    assign rx_right    = rx_right_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Bench for i2s_codec_master: default instance checked every cycle against a frame-level model,
// plus a BCLK_DIV=2 instance for framing checks.
module tb_i2s_codec_master;

    localparam int D = 8;
    localparam int S = 32;
    localparam int W = 24;
    localparam int FRAME_CYC = 4 * S * D;
    localparam int LOAD0     = 2 * D - 1;
    localparam int RX0       = LOAD0 + (S + W) * 2 * D + D + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, tx_valid, tx_ready, tx_underrun, rx_valid;
    logic          bclk, adclrck, daclrck, adcdat, dacdat;
    logic [W-1:0]  tx_left, tx_right, rx_left, rx_right;
    assign dacdat = adcdat;

    logic          rst2_n, tx2_valid, tx2_ready, tx2_underrun, rx2_valid;
    logic          bclk2, adclrck2, daclrck2, adcdat2, dacdat2;
    logic [W-1:0]  tx2_left, tx2_right, rx2_left, rx2_right;
    assign dacdat2 = adcdat2;

    i2s_codec_master #(.DATA_W(W), .SLOT_W(S), .BCLK_DIV(D)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun),
        .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
        .bclk(bclk), .adclrck(adclrck), .daclrck(daclrck),
        .adcdat(adcdat), .dacdat(dacdat)
    );

    i2s_codec_master #(.DATA_W(W), .SLOT_W(S), .BCLK_DIV(2)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst2_n),
        .tx_left(tx2_left), .tx_right(tx2_right), .tx_valid(tx2_valid),
        .tx_ready(tx2_ready), .tx_underrun(tx2_underrun),
        .rx_left(rx2_left), .rx_right(rx2_right), .rx_valid(rx2_valid),
        .bclk(bclk2), .adclrck(adclrck2), .daclrck(daclrck2),
        .adcdat(adcdat2), .dacdat(dacdat2)
    );

    int tests = 0;
    int fails = 0;
    int n  = -1;
    int n2 = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    // Frame-level model: which pair each frame carries, and where each bit must appear in time.
    logic          m_rdy, m_hold, m_und, m_rxv;
    logic [W-1:0]  m_hl, m_hr, m_rxl, m_rxr, wd;
    logic [W-1:0]  fr_l[$];
    logic [W-1:0]  fr_r[$];
    logic          s_rst, s_tv, s_acc, e_bclk, e_lr, e_dat;
    logic [W-1:0]  s_tl, s_tr;
    int            tog, falls, k, fi, b, p;

    initial begin : compare
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_tv = tx_valid; s_tl = tx_left; s_tr = tx_right;
            if (!s_rst) begin
                n = -1; m_rdy = 0; m_hold = 0; m_und = 0; m_rxv = 0;
                m_rxl = '0; m_rxr = '0;
                fr_l.delete(); fr_r.delete();
            end else begin
                n++;
                m_und = 0; m_rxv = 0;
                s_acc = s_tv && m_rdy;
                if (n >= LOAD0 && (n - LOAD0) % FRAME_CYC == 0) begin
                    if (m_hold) begin
                        fr_l.push_back(m_hl); fr_r.push_back(m_hr);
                    end else begin
                        fr_l.push_back('0); fr_r.push_back('0); m_und = 1;
                    end
                    m_hold = 0;
                end
                if (s_acc) begin
                    m_hold = 1; m_hl = s_tl; m_hr = s_tr;
                end
                m_rdy = !m_hold;
                if (n >= RX0 && (n - RX0) % FRAME_CYC == 0) begin
                    fi = (n - RX0) / FRAME_CYC;
                    m_rxl = fr_l[fi]; m_rxr = fr_r[fi]; m_rxv = 1;
                end
            end
            #1;
            e_bclk = 0; e_lr = 0; e_dat = 0;
            if (n >= 0) begin
                tog    = (n + 1) / D;
                e_bclk = (tog % 2) == 1;
                falls  = tog / 2;
                if (falls > 0) begin
                    k  = falls - 1;
                    fi = k / (2 * S);
                    b  = k % (2 * S);
                    e_lr = (b >= S);
                    p  = b % S;
                    if (p >= 1 && p <= W) begin
                        wd = e_lr ? fr_r[fi] : fr_l[fi];
                        wd = wd << (p - 1);
                        e_dat = wd[W-1];
                    end
                end
            end
            check("outputs",
                  64'({bclk, adclrck, daclrck, adcdat, tx_ready, tx_underrun, rx_valid, rx_left, rx_right}),
                  64'({e_bclk, e_lr, e_lr, e_dat, m_rdy, m_und, m_rxv, m_rxl, m_rxr}));
        end
    end

    initial begin : count2
        forever begin
            @(posedge clk);
            if (!rst2_n) n2 = -1;
            else n2++;
        end
    end

    task automatic goto_edge(input int c);
        int guard = 0;
        while (n < c && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n != c) check("goto_edge", 64'(n), 64'(c));
    endtask

    task automatic goto2(input int c);
        int guard = 0;
        while (n2 < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (n2 != c) check("goto2", 64'(n2), 64'(c));
    endtask

    task automatic wait_rx(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                at = n;
                break;
            end
        end
    endtask

    task automatic apply_reset(input int cyc);
        rst_n = 0; tx_valid = 0;
        repeat (cyc) @(negedge clk);
        check("rst_ready",  64'(tx_ready), 64'(0));
        check("rst_bclk",   64'(bclk), 64'(0));
        check("rst_rx",     64'({rx_valid, rx_left, rx_right}), 64'(0));
        rst_n = 1;
    endtask

    // Timeline after a release with nothing offered on tx.
    task automatic fresh_timeline();
        int at;
        goto_edge(0);  check("ready_c0", 64'(tx_ready), 64'(1));
        goto_edge(6);  check("bclk_c6",  64'(bclk), 64'(0));
        goto_edge(7);  check("bclk_c7",  64'(bclk), 64'(1));
        goto_edge(14); check("bclk_c14", 64'(bclk), 64'(1));
        goto_edge(15); check("bclk_c15", 64'(bclk), 64'(0));
        check("und_c15", 64'(tx_underrun), 64'(1));
        goto_edge(16); check("und_c16", 64'(tx_underrun), 64'(0));
        wait_rx(1000, at);
        check("rx_cyc_und", 64'(at), 64'(920));
        check("rx_und", 64'({rx_left, rx_right}), 64'(0));
    endtask

    logic [63:0] fbits;
    logic        prev;
    int          r1, r2, rx2_at;
    logic [W-1:0] rl2, rr2;

    initial begin : stim
        int at;
        rst_n = 0; tx_valid = 0; tx_left = '0; tx_right = '0;
        rst2_n = 0; tx2_valid = 0; tx2_left = '0; tx2_right = '0;
        @(negedge clk);

        // Reset timing and underrun frame
        apply_reset(5);
        fresh_timeline();

        // Loopback, then simultaneous offer on a load edge
        apply_reset(5);
        goto_edge(2);  tx_left = 24'hABCDEF; tx_right = 24'h123456; tx_valid = 1;
        goto_edge(3);  tx_valid = 0; check("ready_full", 64'(tx_ready), 64'(0));
        goto_edge(15); check("no_und_f0", 64'(tx_underrun), 64'(0));
        check("ready_after_load", 64'(tx_ready), 64'(1));
        goto_edge(19); tx_left = 24'h800001; tx_right = 24'h7FFFFF; tx_valid = 1;
        goto_edge(20); tx_valid = 0;
        wait_rx(1000, at);
        check("rx_cyc_f0", 64'(at), 64'(920));
        check("rx_f0", 64'({rx_left, rx_right}), 64'({24'hABCDEF, 24'h123456}));
        goto_edge(1038); tx_left = 24'h13579B; tx_right = 24'h2468AC; tx_valid = 1;
        check("ready_1038", 64'(tx_ready), 64'(0));
        goto_edge(1039); check("ready_1039", 64'(tx_ready), 64'(1));
        check("no_und_1039", 64'(tx_underrun), 64'(0));
        goto_edge(1040); tx_valid = 0; check("ready_1040", 64'(tx_ready), 64'(0));
        wait_rx(1100, at);
        check("rx_cyc_f1", 64'(at), 64'(1944));
        check("rx_f1", 64'({rx_left, rx_right}), 64'({24'h800001, 24'h7FFFFF}));
        goto_edge(2062); check("ready_2062", 64'(tx_ready), 64'(0));
        goto_edge(2063); check("ready_2063", 64'(tx_ready), 64'(1));
        check("no_und_2063", 64'(tx_underrun), 64'(0));
        wait_rx(1100, at);
        check("rx_cyc_f2", 64'(at), 64'(2968));
        check("rx_f2", 64'({rx_left, rx_right}), 64'({24'h13579B, 24'h2468AC}));

        // Pending pair, then reset inside bit 40 of frame 3
        goto_edge(3099); tx_left = 24'hFFFFFF; tx_right = 24'h000001; tx_valid = 1;
        goto_edge(3100); tx_valid = 0;
        goto_edge(3729);
        apply_reset(5);
        fresh_timeline();

        // Framing on the fast instance
        rst2_n = 1;
        goto2(0); tx2_left = 24'h800001; tx2_right = 24'h7FFFFF; tx2_valid = 1;
        goto2(1); tx2_valid = 0;
        fbits = '0; prev = 0; r1 = -1; r2 = -1; rx2_at = -1; rl2 = '0; rr2 = '0;
        for (int c = 2; c <= 400; c++) begin
            goto2(c);
            if (adclrck2 && !prev) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            prev = adclrck2;
            if (c >= 3 && (c - 3) % 4 == 0 && (c - 3) / 4 < 64) fbits = {fbits[62:0], adcdat2};
            if (rx2_valid && rx2_at < 0) begin
                rx2_at = c; rl2 = rx2_left; rr2 = rx2_right;
            end
        end
        check("lrck_rise",   64'(r1), 64'(131));
        check("lrck_period", 64'(r2 - r1), 64'(256));
        check("left_word",   64'(fbits[62:39]), 64'(24'h800001));
        check("right_word",  64'(fbits[30:7]),  64'(24'h7FFFFF));
        check("pad_bits",    64'({fbits[63], fbits[38:32], fbits[31], fbits[6:0]}), 64'(0));
        check("rx2_cyc",     64'(rx2_at), 64'(230));
        check("rx2_data",    64'({rl2, rr2}), 64'({24'h800001, 24'h7FFFFF}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
